// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the memory stage.
// Hits complete combinationally; misses run a beat-serial writeback then refill over req/ready.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// ST_IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or REFILL
// ST_WRITEBACK | streaming the dirty victim line out, one word per accepted beat
// ST_REFILL    | fetching the requested line, one word per accepted beat
module data_cache_ctrl #(
   parameter int SETS           = 64,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   input  logic [3:0]            cpu_byte_en,
   output logic [31:0]           cpu_rdata,
   output logic                  cache_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic [31:0]           mem_rdata
);

   localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
   localparam int OFF_BITS  = WORD_BITS + 2;
   localparam int IDX_BITS  = $clog2(SETS);
   localparam int IDX_MSB   = OFF_BITS + IDX_BITS - 1;
   localparam int TAG_BITS  = ADDR_WIDTH - IDX_MSB - 1;
   localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITEBACK,
      ST_REFILL
   } state_t;

   state_t                state_q, state_d;
   logic [WORD_BITS-1:0]  beat_q, beat_d;
   logic [SETS-1:0]       valid_q, valid_d;
   logic [SETS-1:0]       dirty_q, dirty_d;
   logic [TAG_BITS-1:0]   tag_q [SETS];
   logic [31:0]           data_q [SETS][WORDS_PER_LINE];

   logic [IDX_BITS-1:0]   idx;
   logic [WORD_BITS-1:0]  word_sel;
   logic [TAG_BITS-1:0]   addr_tag;
   logic                  access;
   logic                  is_store;
   logic                  hit;
   logic                  last_beat;
   logic [31:0]           hit_word;
   logic [31:0]           merged_word;

   logic                  tag_we;
   logic                  line_we;
   logic [WORD_BITS-1:0]  line_word;
   logic [31:0]           line_wdata;

   logic                  unused_addr_bits;

   assign idx              = cpu_addr[IDX_MSB:OFF_BITS];
   assign word_sel         = cpu_addr[OFF_BITS-1:2];
   assign addr_tag         = cpu_addr[ADDR_WIDTH-1:IDX_MSB+1];
   assign unused_addr_bits = ^cpu_addr[1:0];

   // a simultaneous re/we is a store
   assign access    = cpu_re | cpu_we;
   assign is_store  = cpu_we;
   assign hit       = valid_q[idx] & (tag_q[idx] == addr_tag);
   assign last_beat = (beat_q == LAST_BEAT);
   assign hit_word  = data_q[idx][word_sel];

   always_comb begin
      merged_word = hit_word;
      for (int b = 0; b < 4; b++) begin
         if (cpu_byte_en[b]) merged_word[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      tag_we     = 1'b0;
      line_we    = 1'b0;
      line_word  = word_sel;
      line_wdata = merged_word;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               if (hit) begin
                  if (is_store) begin
                     line_we      = 1'b1;
                     dirty_d[idx] = 1'b1;
                  end
               end else begin
                  beat_d  = '0;
                  state_d = (valid_q[idx] & dirty_q[idx]) ? ST_WRITEBACK : ST_REFILL;
               end
            end
         end
         ST_WRITEBACK: begin
            if (mem_ready) begin
               beat_d = last_beat ? '0 : beat_q + 1'b1;
               if (last_beat) state_d = ST_REFILL;
            end
         end
         ST_REFILL: begin
            if (mem_ready) begin
               line_we    = 1'b1;
               line_word  = beat_q;
               line_wdata = mem_rdata;
               beat_d     = last_beat ? '0 : beat_q + 1'b1;
               if (last_beat) begin
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // memory-side outputs decode straight from the state flops
   always_comb begin
      mem_req   = (state_q != ST_IDLE);
      mem_we    = (state_q == ST_WRITEBACK);
      mem_wdata = data_q[idx][beat_q];
      case (state_q)
         ST_WRITEBACK: mem_addr = {tag_q[idx], idx, beat_q, 2'b00};
         ST_REFILL:    mem_addr = {addr_tag, idx, beat_q, 2'b00};
         default:      mem_addr = '0;
      endcase
   end

   assign cpu_rdata   = hit_word;
   assign cache_stall = (state_q != ST_IDLE) | (access & ~hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // tag and data arrays carry no reset; the valid bits guard them
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (tag_we)  tag_q[idx] <= addr_tag;
         if (line_we) data_q[idx][line_word] <= line_wdata;
      end
   end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized and directed bench for data_cache_ctrl, checked against a line-level cache
// model plus a flat main-memory image kept in the bench.
module tb_data_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_re, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_byte_en;
   logic [31:0] cpu_rdata;
   logic        cache_stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   data_cache_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_re      (cpu_re),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_byte_en (cpu_byte_en),
      .cpu_rdata   (cpu_rdata),
      .cache_stall (cache_stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata)
   );

   int errors = 0;
   int checks = 0;

   // main memory as seen by the DUT, and the reference image the model maintains
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // reference cache: 64 sets x 4 words, index = addr[9:4], tag = addr[31:10]
   logic        ref_valid [64];
   logic        ref_dirty [64];
   logic [21:0] ref_tag   [64];
   logic [31:0] ref_data  [64][4];

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } beat_t;
   beat_t exp_q[$];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return init_val(a);
   endfunction

   function logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         ref_valid[i] = 1'b0;
         ref_dirty[i] = 1'b0;
      end
   endtask

   // Builds the expected beat list and updates the reference state for one access.
   task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic exp_hit,
                               output logic [31:0] exp_rdata);
      int          idx;
      int          w;
      logic [21:0] tag;
      logic [31:0] a;
      idx = int'(addr[9:4]);
      w   = int'(addr[3:2]);
      tag = addr[31:10];
      exp_q.delete();
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
      if (!exp_hit) begin
         if (ref_valid[idx] && ref_dirty[idx]) begin
            for (int b = 0; b < 4; b++) begin
               a = {ref_tag[idx], 6'(idx), 2'(b), 2'b00};
               exp_q.push_back('{addr: a, we: 1'b1, data: ref_data[idx][b]});
               ref_mem[a] = ref_data[idx][b];
            end
         end
         for (int b = 0; b < 4; b++) begin
            a = {tag, 6'(idx), 2'(b), 2'b00};
            exp_q.push_back('{addr: a, we: 1'b0, data: 32'h0});
            ref_data[idx][b] = ref_rd(a);
         end
         ref_tag[idx]   = tag;
         ref_valid[idx] = 1'b1;
         ref_dirty[idx] = 1'b0;
      end
      exp_rdata = ref_data[idx][w];
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_data[idx][w][8*b +: 8] = wdata[8*b +: 8];
         ref_dirty[idx] = 1'b1;
      end
   endtask

   function automatic int pick_wait(input int mode, input int nb);
      if (mode == 1) return int'($urandom_range(0, 2));
      if (mode == 2) return (nb == 0) ? 5 : 0;
      return 0;
   endfunction

   // One CPU access: drives it, plays memory, checks every beat and the final result.
   task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int wait_mode,
                            output int stalls, output logic [31:0] rdata);
      logic        exp_hit;
      logic [31:0] exp_rdata;
      int          nb, waits, wl, exp_stalls;
      bit          done;
      model_access(we, addr, wdata, be, exp_hit, exp_rdata);
      @(negedge clk);
      cpu_re      = re;
      cpu_we      = we;
      cpu_addr    = addr;
      cpu_wdata   = wdata;
      cpu_byte_en = be;
      stalls = 0; nb = 0; waits = 0; done = 0; rdata = 'x;
      wl = pick_wait(wait_mode, 0);
      for (int c = 0; c < 200 && !done; c++) begin
         #1;
         mem_ready = 1'b0;
         if (mem_req) begin
            mem_ready = (wl == 0);
            if (!mem_we) mem_rdata = mem_rd(mem_addr);
         end
         #1;
         if (!cache_stall) begin
            done  = 1;
            rdata = cpu_rdata;
            checks++;
            if (mem_req !== 1'b0) begin
               errors++;
               $display("FAIL done_req: mem_req=%b required 0 at %h", mem_req, addr);
            end
         end else begin
            stalls++;
            if (mem_req) begin
               checks++;
               if (nb >= exp_q.size()) begin
                  errors++;
                  $display("FAIL extra_beat: addr=%h we=%b beyond %0d expected beats",
                           mem_addr, mem_we, exp_q.size());
               end else if (mem_we !== exp_q[nb].we || mem_addr !== exp_q[nb].addr ||
                            (exp_q[nb].we && mem_wdata !== exp_q[nb].data)) begin
                  errors++;
                  $display("FAIL beat%0d: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                           nb, mem_addr, mem_we, mem_wdata,
                           exp_q[nb].addr, exp_q[nb].we, exp_q[nb].data);
               end
               if (mem_ready) begin
                  if (mem_we) mem[mem_addr] = mem_wdata;
                  nb++;
                  wl = pick_wait(wait_mode, nb);
               end else begin
                  wl--;
                  waits++;
               end
            end
            @(negedge clk);
         end
      end
      mem_ready = 1'b0;
      exp_stalls = exp_hit ? 0 : 1 + exp_q.size() + waits;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout: access %h still stalled after 200 cycles", addr);
      end else if (nb != exp_q.size() || stalls != exp_stalls) begin
         errors++;
         $display("FAIL latency: beats=%0d stalls=%0d required beats=%0d stalls=%0d at %h",
                  nb, stalls, exp_q.size(), exp_stalls, addr);
      end
      if (!we && done) begin
         checks++;
         if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL load_data: rdata=%h required %h at %h", rdata, exp_rdata, addr);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (cache_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: stall=%b req=%b we=%b required 0 0 0",
                  cache_stall, mem_req, mem_we);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_refill();
      int          st;
      logic [31:0] rd;
      for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4*i), 32'hA0A0_0000 + 32'(i));
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 5 || rd !== 32'hA0A0_0000) begin
         errors++;
         $display("FAIL clean_miss: stalls=%0d rdata=%h required 5 A0A00000", st, rd);
      end
      do_access(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 0 || rd !== 32'hA0A0_0002) begin
         errors++;
         $display("FAIL hit_load: stalls=%0d rdata=%h required 0 A0A00002", st, rd);
      end
   endtask

   task automatic test_dirty_evict();
      int          st;
      logic [31:0] rd;
      do_access(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 0, st, rd);
      checks++;
      if (st != 0) begin
         errors++;
         $display("FAIL store_hit: stalls=%0d required 0", st);
      end
      do_access(1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 9 || mem_rd(32'h104) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL dirty_miss: stalls=%0d mem[104]=%h required 9 DEADBEEF",
                  st, mem_rd(32'h104));
      end
   endtask

   task automatic test_byte_store();
      int          st;
      logic [31:0] rd;
      do_access(1'b0, 1'b1, 32'h104, 32'h1122_3344, 4'hF, 0, st, rd);
      do_access(1'b0, 1'b1, 32'h104, 32'h0000_5500, 4'b0010, 0, st, rd);
      do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 0 || rd !== 32'h1122_5544) begin
         errors++;
         $display("FAIL byte_merge: stalls=%0d rdata=%h required 0 11225544", st, rd);
      end
      do_access(1'b1, 1'b0, 32'h504, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 9 || mem_rd(32'h104) !== 32'h1122_5544) begin
         errors++;
         $display("FAIL byte_dirty: stalls=%0d mem[104]=%h required 9 11225544",
                  st, mem_rd(32'h104));
      end
   endtask

   task automatic test_ready_stall();
      int          st;
      logic [31:0] rd;
      test_reset();
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 2, st, rd);
      checks++;
      if (st != 10) begin
         errors++;
         $display("FAIL ready_low: stalls=%0d required 10", st);
      end
   endtask

   task automatic test_reset_mid_miss();
      int          st, beats;
      logic [31:0] rd;
      test_reset();
      @(negedge clk);
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
         #1 mem_rdata = mem_rd(mem_addr);
         #1 if (mem_req) beats++;
         @(negedge clk);
      end
      rst = 1'b1; cpu_re = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (beats != 2 || mem_req !== 1'b0 || cache_stall !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: beats=%0d req=%b stall=%b required 2 0 0",
                  beats, mem_req, cache_stall);
      end
      rst = 1'b0;
      model_reset();
      do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, st, rd);
      checks++;
      if (st != 5) begin
         errors++;
         $display("FAIL post_reset_miss: stalls=%0d required 5", st);
      end
   endtask

   task automatic test_idle();
      @(negedge clk);
      cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = $urandom;
      for (int c = 0; c < 10; c++) begin
         #1;
         checks++;
         if (cache_stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle: cycle %0d stall=%b req=%b required 0 0", c, cache_stall, mem_req);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int          st;
      logic [31:0] rd, d;
      do_access(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 0, st, rd);
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         do_access(1'b0, 1'b1, 32'h300 + 32'(4*(i%4)), d, 4'(i + 3), 0, st, rd);
         do_access(1'b1, 1'b0, 32'h300 + 32'(4*(i%4)), 32'h0, 4'h0, 0, st, rd);
      end
   endtask

   task automatic test_random();
      int          st;
      logic [31:0] rd, a;
      logic        re, we;
      for (int n = 0; n < 400; n++) begin
         a = {20'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 3)), 2'($urandom),
              2'($urandom)};
         if ($urandom_range(0, 9) == 0) a[9:4] = 6'($urandom);
         we = $urandom_range(0, 1) == 1;
         re = we ? ($urandom_range(0, 1) == 1) : 1'b1;
         do_access(re, we, a, $urandom, 4'($urandom), 1, st, rd);
      end
      foreach (ref_mem[k]) begin
         checks++;
         if (mem_rd(k) !== ref_mem[k]) begin
            errors++;
            $display("FAIL mem_image: mem[%h]=%h required %h", k, mem_rd(k), ref_mem[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      cpu_byte_en = '0; mem_ready = 1'b0; mem_rdata = '0;
      test_reset();
      test_clean_refill();
      test_dirty_evict();
      test_byte_store();
      test_ready_stall();
      test_reset_mid_miss();
      test_idle();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
